// File: rtl/mem_pkg.sv
// Shared types and constants for the load/store front end: FSM states,
// address decode regions, I/O window offsets and the address decoder.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_CAPTURE,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_IO,
    REG_UNMAPPED
  } region_e;

  localparam logic [15:0] IO_BASE_DEF = 16'hFFF0;
  localparam logic [3:0]  IO_SW_OFS   = 4'd0;
  localparam logic [3:0]  IO_LED_OFS  = 4'd1;
  localparam int unsigned IO_WORDS    = 16;

  // 17-bit compares so an I/O window ending at 16'hFFFF does not wrap.
  function automatic region_e decode_addr(input logic [15:0] a,
                                          input int unsigned aw,
                                          input logic [15:0] base,
                                          input logic io_en);
    logic [16:0] a_x;
    logic [16:0] base_x;
    logic [16:0] ram_top;
    a_x     = {1'b0, a};
    base_x  = {1'b0, base};
    ram_top = 17'd1 << aw;
    if (a_x < ram_top) return REG_RAM;
    if (io_en && (a_x >= base_x) && (a_x < base_x + 17'(IO_WORDS))) return REG_IO;
    return REG_UNMAPPED;
  endfunction

endpackage

// File: rtl/mem_io_regs.sv
// Memory-mapped I/O window: LED register and the I/O read mux.
// Only instantiated when MEM_IO_EN is defined.
module mem_io_regs
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  wr_en_i,
  input  logic [3:0]            ofs_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [15:0]           io_sw_i,
  output logic [15:0]           io_led_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [15:0] led_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      led_q <= '0;
    end else if (wr_en_i && (ofs_i == IO_LED_OFS)) begin
      led_q <= 16'(wdata_i);
    end
  end

  always_comb begin
    rdata_o = '0;
    case (ofs_i)
      IO_SW_OFS:  rdata_o = DATA_WIDTH'(io_sw_i);
      IO_LED_OFS: rdata_o = DATA_WIDTH'(led_q);
      default:    rdata_o = '0;
    endcase
  end

  assign io_led_o = led_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store front end for port A of the dual-port RAM with a small I/O window.
// Define MEM_IO_EN to compile in the I/O window (io_sw read, io_led register).
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [15:0] IO_BASE    = IO_BASE_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [15:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  done,
  output logic                  err,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,
  input  logic [15:0]           io_sw,
  output logic [15:0]           io_led
);

`ifdef MEM_IO_EN
  localparam logic IO_EN = 1'b1;
`else
  localparam logic IO_EN = 1'b0;
`endif

  state_e                state_q;
  region_e               region_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            io_ofs_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  done_q;
  logic                  err_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] io_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      region_q <= REG_RAM;
      we_q     <= 1'b0;
      addr_q   <= '0;
      io_ofs_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            we_q     <= we;
            addr_q   <= addr[ADDR_WIDTH-1:0];
            io_ofs_q <= 4'(addr - IO_BASE);
            wdata_q  <= wdata;
            region_q <= decode_addr(addr, ADDR_WIDTH, IO_BASE, IO_EN);
            busy_q   <= 1'b1;
            state_q  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          case (region_q)
            REG_RAM: state_q <= we_q ? S_DONE : S_CAPTURE;
            REG_IO: begin
              if (!we_q) rdata_q <= io_rdata;
              state_q <= S_DONE;
            end
            default: begin
              if (!we_q) rdata_q <= '0;
              state_q <= S_DONE;
            end
          endcase
        end
        S_CAPTURE: begin
          rdata_q <= ram_q;
          state_q <= S_DONE;
        end
        S_DONE: begin
          // done/err are registered, so they appear the cycle after DONE,
          // which is also the IDLE cycle that may re-accept a held req.
          done_q  <= 1'b1;
          err_q   <= (region_q == REG_UNMAPPED);
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_addr = (state_q == S_ACCESS) ? addr_q : '0;
  assign ram_data = (state_q == S_ACCESS) ? wdata_q : '0;
  assign ram_we   = (state_q == S_ACCESS) && we_q && (region_q == REG_RAM) && !reset;

`ifdef MEM_IO_EN
  logic io_wr;
  assign io_wr = (state_q == S_ACCESS) && we_q && (region_q == REG_IO);

  mem_io_regs #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_io_regs (
    .clk_i    (clk),
    .reset_i  (reset),
    .wr_en_i  (io_wr),
    .ofs_i    (io_ofs_q),
    .wdata_i  (wdata_q),
    .io_sw_i  (io_sw),
    .io_led_o (io_led),
    .rdata_o  (io_rdata)
  );
`else
  logic unused_io;
  assign unused_io = ^{io_sw, io_ofs_q};
  assign io_rdata  = '0;
  assign io_led    = '0;
`endif

  assign rdata = rdata_q;
  assign done  = done_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store front end between the CPU datapath and port A of the 16-bit dual-port RAM. Accepts one word-sized load or store per request, drives the RAM's synchronous-read port with the correct wait state, and returns read data with a one-cycle `done` pulse. Decodes a small memory-mapped I/O window above RAM. Port B of the RAM stays free for instruction fetch.

## Interface
Parameters:
- `DATA_WIDTH`, 16, word width of CPU and RAM data.
- `ADDR_WIDTH`, 10, RAM word-address width; RAM spans 0 to 2^ADDR_WIDTH-1.
- `IO_BASE`, 16'hFFF0, first address of the I/O window (16 words).

Ports:
- `clk`, in, 1, single clock; all logic is rising-edge.
- `reset`, in, 1, synchronous, active-high.
- `req`, in, 1, access request; sampled only in IDLE.
- `we`, in, 1, 1 = store, 0 = load; sampled with `req`.
- `addr`, in, 16, CPU word address; sampled with `req`.
- `wdata`, in, DATA_WIDTH, store data; sampled with `req`.
- `rdata`, out, DATA_WIDTH, load result; valid while `done` = 1 and held until the next load completes.
- `done`, out, 1, one-cycle completion pulse.
- `err`, out, 1, pulses with `done` when the address was unmapped.
- `busy`, out, 1, high in every state except IDLE.
- `ram_addr`, out, ADDR_WIDTH, to RAM `addr_a`.
- `ram_data`, out, DATA_WIDTH, to RAM `data_a`.
- `ram_we`, out, 1, to RAM `we_a`.
- `ram_q`, in, DATA_WIDTH, from RAM `q_a_out`; valid one cycle after the address is clocked in.
- `io_sw`, in, 16, switch inputs, readable at IO_BASE+0.
- `io_led`, out, 16, LED register, read/write at IO_BASE+1.

## Operation
- States: IDLE, ACCESS, CAPTURE, DONE.
- IDLE: if `req`=1, latch `we`/`addr`/`wdata` and go to ACCESS. Otherwise stay.
- ACCESS: `ram_addr` = latched addr[ADDR_WIDTH-1:0] and `ram_data` = latched wdata.
  - RAM store: `ram_we`=1 for this cycle only, then go to DONE.
  - RAM load: go to CAPTURE.
  - I/O or unmapped access: completes here and goes to DONE. A store to IO_BASE+1 updates `io_led`. A load latches the I/O value into `rdata`.
- CAPTURE: register `ram_q` into `rdata`, then go to DONE.
- DONE: `done`=1 (and `err` if flagged), then go to IDLE.
- Decode:
  - addr < 2^ADDR_WIDTH → RAM.
  - addr in IO_BASE..IO_BASE+15 → I/O.
  - Anything else → unmapped.
- I/O window: IO_BASE+0 = `io_sw`, IO_BASE+1 = `io_led`. Other I/O offsets read 0 and ignore stores (no `err`).
- Unmapped access: stores are dropped, loads return 0, `err`=1 with `done`.
- `req` while busy is ignored, not queued. If `req` is held through DONE, it is re-accepted in the following IDLE cycle.
- `ram_we` is gated with `!reset`: reset asserted during ACCESS commits no RAM write.

## Timing
- Reset values: state IDLE; `rdata`=0, `done`=0, `err`=0, `busy`=0, `ram_we`=0, `ram_addr`=0, `ram_data`=0, `io_led`=0.
- All outputs except `ram_*` are registered. `ram_*` are decoded from state plus latched registers.
- Latency, counting edge 0 as the edge that samples `req`:
  - RAM load: `done` high in the cycle after edge 3.
  - RAM store: `done` high after edge 2.
  - I/O or unmapped access: `done` high after edge 2.
- Throughput: with `req` held high, one RAM load per 4 cycles and one store per 3 cycles.
- Reset mid-operation:
  - The FSM returns to IDLE on that edge.
  - A pending `done` is cancelled.
  - `rdata` and `io_led` are cleared.

## Configuration
- `MEM_IO_EN`: compiles in the I/O window, `io_sw` decoding and the `io_led` register.
- Without it:
  - The I/O range decodes as unmapped (loads return 0, `err`=1).
  - `io_led` is tied to 0.
  - `io_sw` is unused.

## Structure
- Shared package `mem_pkg`: state encoding enum, `IO_BASE` default, I/O offset constants (`IO_SW_OFS`=0, `IO_LED_OFS`=1), and the decode-region enum (RAM/IO/UNMAPPED).
- One sub-module: `mem_io_regs` holds the `io_led` register and the I/O read mux. It is instantiated only under `MEM_IO_EN`.

## Test plan
- Store 16'hBEEF to addr 5, then load addr 5 → store `done` 2 cycles after accept; load `done` 3 cycles after accept with `rdata`=16'hBEEF, `err`=0.
- Load back-to-back with `req` held high at addr 0 then addr 1 (preloaded 16'h1111, 16'h2222) → `done` every 4 cycles, returning 16'h1111 then 16'h2222. `req` during `busy` is not double-counted.
- Store 16'h00A5 to 16'hFFF1, then load 16'hFFF1 and 16'hFFF0 with `io_sw`=16'h1234 → `io_led`=16'h00A5, loads return 16'h00A5 and 16'h1234. Without `MEM_IO_EN`: both loads return 0 with `err`=1.
- Store to 16'h0400 (unmapped) → no `ram_we` pulse, `err`=1 with `done`. A following load of 16'h0400 returns 0 with `err`=1.
- Assert `reset` in the ACCESS cycle of a store of 16'hDEAD to addr 7 → `ram_we` stays 0, no `done`, `busy`=0 next cycle; a later load of addr 7 returns the old value.
